// File: rtl/ahb_trace_mon.sv
// AHB-Lite master-port trace monitor: pairs address and data phases into
// records, filters them by address window and queues them in a FIFO.
module ahb_trace_mon #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic              hclk,
   input  logic              hrst_b,
   input  logic [ADDR_W-1:0] mon_haddr,
   input  logic [1:0]        mon_htrans,
   input  logic              mon_hwrite,
   input  logic [2:0]        mon_hsize,
   input  logic [2:0]        mon_hburst,
   input  logic [DATA_W-1:0] mon_hwdata,
   input  logic [DATA_W-1:0] mon_hrdata,
   input  logic              mon_hready,
   input  logic              cfg_en,
   input  logic              cfg_wrap,
   input  logic [ADDR_W-1:0] cfg_win_base,
   input  logic [ADDR_W-1:0] cfg_win_mask,
   output logic              trc_valid,
   input  logic              trc_ready,
   output logic [ADDR_W-1:0] trc_addr,
   output logic [DATA_W-1:0] trc_data,
   output logic              trc_write,
   output logic [2:0]        trc_size,
   output logic [2:0]        trc_burst,
   output logic [LVL_W-1:0]  level,
   output logic              full,
   output logic [15:0]       ovf_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int REC_W = ADDR_W + DATA_W + 7;

   logic              accept;
   logic              push;
   logic              pop;
   logic              wr_en;
   logic              unused_htrans;

   logic              pend_vld_q, pend_vld_d;
   logic [ADDR_W-1:0] pend_addr_q;
   logic              pend_write_q;
   logic [2:0]        pend_size_q;
   logic [2:0]        pend_burst_q;

   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [15:0]       ovf_q, ovf_d;

   logic [REC_W-1:0]  mem_q [DEPTH];
   logic [REC_W-1:0]  rec_new;
   logic [REC_W-1:0]  rec_head;

   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic              head_write;
   logic [2:0]        head_size;
   logic [2:0]        head_burst;

   assign unused_htrans = mon_htrans[0];

   assign accept = mon_hready & mon_htrans[1] & cfg_en &
                   ((mon_haddr & cfg_win_mask) == (cfg_win_base & cfg_win_mask));
   assign push   = mon_hready & pend_vld_q;
   assign pop    = trc_valid & trc_ready;

   assign rec_new = {pend_addr_q, (pend_write_q ? mon_hwdata : mon_hrdata),
                     pend_write_q, pend_size_q, pend_burst_q};

   // A completing edge either retires the pending phase or replaces it with
   // the next pipelined address phase; wait states hold it untouched.
   always_comb begin
      pend_vld_d = pend_vld_q;
      if (mon_hready) begin
         pend_vld_d = accept;
      end
   end

   always_ff @(posedge hclk or negedge hrst_b) begin
      if (!hrst_b) begin
         pend_vld_q   <= 1'b0;
         pend_addr_q  <= '0;
         pend_write_q <= 1'b0;
         pend_size_q  <= '0;
         pend_burst_q <= '0;
      end else begin
         pend_vld_q <= pend_vld_d;
         if (accept) begin
            pend_addr_q  <= mon_haddr;
            pend_write_q <= mon_hwrite;
            pend_size_q  <= mon_hsize;
            pend_burst_q <= mon_hburst;
         end
      end
   end

   // A simultaneous pop frees the slot, so a push into a full FIFO only
   // loses data when nothing is being drained on the same edge.
   always_comb begin
      wr_en   = 1'b0;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      ovf_d   = ovf_q;
      if (push && pop) begin
         wr_en  = 1'b1;
         wptr_d = wptr_q + 1'b1;
         rptr_d = rptr_q + 1'b1;
      end else if (push && !full) begin
         wr_en   = 1'b1;
         wptr_d  = wptr_q + 1'b1;
         level_d = level_q + 1'b1;
      end else if (push) begin
         if (ovf_q != 16'hFFFF) begin
            ovf_d = ovf_q + 16'd1;
         end
         if (cfg_wrap) begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + 1'b1;
            rptr_d = rptr_q + 1'b1;
         end
      end else if (pop) begin
         rptr_d  = rptr_q + 1'b1;
         level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge hclk or negedge hrst_b) begin
      if (!hrst_b) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         ovf_q   <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge hclk) begin
      if (wr_en) begin
         mem_q[wptr_q] <= rec_new;
      end
   end

   assign rec_head = mem_q[rptr_q];
   assign {head_addr, head_data, head_write, head_size, head_burst} = rec_head;

   // Storage is not reset, so the head fields are forced to zero while empty.
   assign trc_valid = (level_q != '0);
   assign trc_addr  = trc_valid ? head_addr  : '0;
   assign trc_data  = trc_valid ? head_data  : '0;
   assign trc_write = trc_valid ? head_write : 1'b0;
   assign trc_size  = trc_valid ? head_size  : '0;
   assign trc_burst = trc_valid ? head_burst : '0;

   assign level   = level_q;
   assign full    = (level_q == LVL_W'(DEPTH));
   assign ovf_cnt = ovf_q;

endmodule

// File: tb/tb_ahb_trace_mon.sv
// Directed self-checking bench for ahb_trace_mon with hand-computed vectors.
module tb_ahb_trace_mon;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] BUSY   = 2'b01;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;

   logic        hclk;
   logic        hrst_b;
   logic [31:0] mon_haddr;
   logic [1:0]  mon_htrans;
   logic        mon_hwrite;
   logic [2:0]  mon_hsize;
   logic [2:0]  mon_hburst;
   logic [31:0] mon_hwdata;
   logic [31:0] mon_hrdata;
   logic        mon_hready;
   logic        cfg_en;
   logic        cfg_wrap;
   logic [31:0] cfg_win_base;
   logic [31:0] cfg_win_mask;
   logic        trc_valid;
   logic        trc_ready;
   logic [31:0] trc_addr;
   logic [31:0] trc_data;
   logic        trc_write;
   logic [2:0]  trc_size;
   logic [2:0]  trc_burst;
   logic [4:0]  level;
   logic        full;
   logic [15:0] ovf_cnt;

   int checks;
   int errors;

   ahb_trace_mon #(.ADDR_W(32), .DATA_W(32), .DEPTH(16)) dut (
      .hclk(hclk), .hrst_b(hrst_b),
      .mon_haddr(mon_haddr), .mon_htrans(mon_htrans), .mon_hwrite(mon_hwrite),
      .mon_hsize(mon_hsize), .mon_hburst(mon_hburst), .mon_hwdata(mon_hwdata),
      .mon_hrdata(mon_hrdata), .mon_hready(mon_hready),
      .cfg_en(cfg_en), .cfg_wrap(cfg_wrap),
      .cfg_win_base(cfg_win_base), .cfg_win_mask(cfg_win_mask),
      .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_addr(trc_addr),
      .trc_data(trc_data), .trc_write(trc_write), .trc_size(trc_size),
      .trc_burst(trc_burst), .level(level), .full(full), .ovf_cnt(ovf_cnt)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   // Drive one bus cycle, then settle just after the rising edge.
   task automatic applyStimulus(input logic [1:0] tr, input logic [31:0] ad,
                                input logic wr, input logic [31:0] wd,
                                input logic [31:0] rd, input logic rdy);
      mon_htrans = tr;
      mon_haddr  = ad;
      mon_hwrite = wr;
      mon_hwdata = wd;
      mon_hrdata = rd;
      mon_hready = rdy;
      @(posedge hclk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic popOne();
      trc_ready = 1'b1;
      applyStimulus(IDLE, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
      trc_ready = 1'b0;
   endtask

   task automatic pulseReset();
      hrst_b = 1'b0;
      #3;
      hrst_b = 1'b1;
      @(posedge hclk);
      #1;
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      hrst_b       = 1'b0;
      mon_haddr    = '0;
      mon_htrans   = IDLE;
      mon_hwrite   = 1'b0;
      mon_hsize    = 3'd2;
      mon_hburst   = 3'd1;
      mon_hwdata   = '0;
      mon_hrdata   = '0;
      mon_hready   = 1'b1;
      cfg_en       = 1'b1;
      cfg_wrap     = 1'b0;
      cfg_win_base = '0;
      cfg_win_mask = '0;
      trc_ready    = 1'b0;

      #12;
      checkOutput("rst_valid", {31'd0, trc_valid}, 32'd0);
      checkOutput("rst_level", {27'd0, level}, 32'd0);
      checkOutput("rst_full", {31'd0, full}, 32'd0);
      checkOutput("rst_ovf", {16'd0, ovf_cnt}, 32'd0);
      hrst_b = 1'b1;
      @(posedge hclk);
      #1;

      $display("[TB] single transfer");
      applyStimulus(NONSEQ, 32'h2000_0010, 1'b1, 32'h0, 32'h0, 1'b1);
      checkOutput("single_not_yet", {31'd0, trc_valid}, 32'd0);
      applyStimulus(IDLE, 32'h0, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1);
      checkOutput("single_valid", {31'd0, trc_valid}, 32'd1);
      checkOutput("single_addr", trc_addr, 32'h2000_0010);
      checkOutput("single_data", trc_data, 32'hDEAD_BEEF);
      checkOutput("single_write", {31'd0, trc_write}, 32'd1);
      checkOutput("single_size", {29'd0, trc_size}, 32'd2);
      checkOutput("single_burst", {29'd0, trc_burst}, 32'd1);
      checkOutput("single_level", {27'd0, level}, 32'd1);
      popOne();
      checkOutput("single_drained", {27'd0, level}, 32'd0);

      $display("[TB] wait states and pipelining");
      applyStimulus(NONSEQ, 32'h10, 1'b0, 32'h0, 32'h0, 1'b1);
      applyStimulus(SEQ, 32'h14, 1'b0, 32'h0, 32'hBAD0, 1'b0);
      applyStimulus(SEQ, 32'h14, 1'b0, 32'h0, 32'hBAD1, 1'b0);
      checkOutput("wait_hold", {31'd0, trc_valid}, 32'd0);
      applyStimulus(SEQ, 32'h14, 1'b0, 32'h0, 32'h1234, 1'b1);
      applyStimulus(SEQ, 32'h18, 1'b0, 32'h0, 32'h14AA, 1'b1);
      applyStimulus(BUSY, 32'h1C, 1'b0, 32'h0, 32'h18BB, 1'b1);
      applyStimulus(IDLE, 32'h0, 1'b0, 32'h0, 32'h9999, 1'b1);
      applyStimulus(BUSY, 32'h1C, 1'b0, 32'h0, 32'h8888, 1'b1);
      checkOutput("pipe_level", {27'd0, level}, 32'd3);
      checkOutput("pipe_a0", trc_addr, 32'h10);
      checkOutput("pipe_d0", trc_data, 32'h1234);
      checkOutput("pipe_w0", {31'd0, trc_write}, 32'd0);
      popOne();
      checkOutput("pipe_a1", trc_addr, 32'h14);
      checkOutput("pipe_d1", trc_data, 32'h14AA);
      popOne();
      checkOutput("pipe_a2", trc_addr, 32'h18);
      checkOutput("pipe_d2", trc_data, 32'h18BB);
      popOne();
      checkOutput("pipe_empty", {31'd0, trc_valid}, 32'd0);

      $display("[TB] address filter");
      cfg_win_base = 32'h4000_0000;
      cfg_win_mask = 32'hF000_0000;
      applyStimulus(NONSEQ, 32'h4000_0004, 1'b1, 32'h0, 32'h0, 1'b1);
      applyStimulus(NONSEQ, 32'h5000_0004, 1'b1, 32'hA1, 32'h0, 1'b1);
      applyStimulus(IDLE, 32'h0, 1'b0, 32'hB2, 32'h0, 1'b1);
      checkOutput("filt_level", {27'd0, level}, 32'd1);
      checkOutput("filt_addr", trc_addr, 32'h4000_0004);
      checkOutput("filt_data", trc_data, 32'hA1);
      popOne();
      cfg_win_base = '0;
      cfg_win_mask = '0;

      $display("[TB] overflow stop");
      cfg_wrap = 1'b0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(NONSEQ, 32'h100 + 32'(4 * i), 1'b1, 32'(i - 1), 32'h0, 1'b1);
      end
      applyStimulus(IDLE, 32'h0, 1'b0, 32'd19, 32'h0, 1'b1);
      checkOutput("stop_full", {31'd0, full}, 32'd1);
      checkOutput("stop_level", {27'd0, level}, 32'd16);
      checkOutput("stop_ovf", {16'd0, ovf_cnt}, 32'd4);
      for (int i = 0; i < 16; i++) begin
         checkOutput("stop_drain", trc_data, 32'(i));
         popOne();
      end
      checkOutput("stop_empty", {27'd0, level}, 32'd0);

      $display("[TB] overflow wrap");
      pulseReset();
      cfg_wrap = 1'b1;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(NONSEQ, 32'h100 + 32'(4 * i), 1'b1, 32'(i - 1), 32'h0, 1'b1);
      end
      applyStimulus(IDLE, 32'h0, 1'b0, 32'd19, 32'h0, 1'b1);
      checkOutput("wrap_full", {31'd0, full}, 32'd1);
      checkOutput("wrap_ovf", {16'd0, ovf_cnt}, 32'd4);
      checkOutput("wrap_head", trc_data, 32'd4);
      applyStimulus(NONSEQ, 32'h200, 1'b1, 32'h0, 32'h0, 1'b1);
      trc_ready = 1'b1;
      applyStimulus(IDLE, 32'h0, 1'b0, 32'd100, 32'h0, 1'b1);
      trc_ready = 1'b0;
      checkOutput("pushpop_ovf", {16'd0, ovf_cnt}, 32'd4);
      checkOutput("pushpop_level", {27'd0, level}, 32'd16);
      for (int i = 5; i < 20; i++) begin
         checkOutput("wrap_drain", trc_data, 32'(i));
         popOne();
      end
      checkOutput("wrap_last_addr", trc_addr, 32'h200);
      checkOutput("wrap_last", trc_data, 32'd100);
      popOne();

      $display("[TB] reset mid-flight");
      cfg_wrap = 1'b0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(NONSEQ, 32'h300 + 32'(4 * i), 1'b1, 32'h50 + 32'(i), 32'h0, 1'b1);
      end
      checkOutput("pre_rst_level", {27'd0, level}, 32'd5);
      checkOutput("pre_rst_ovf", {16'd0, ovf_cnt}, 32'd4);
      mon_htrans = IDLE;
      mon_hwdata = 32'hEEEE;
      hrst_b = 1'b0;
      #1;
      checkOutput("midrst_level", {27'd0, level}, 32'd0);
      checkOutput("midrst_valid", {31'd0, trc_valid}, 32'd0);
      checkOutput("midrst_ovf", {16'd0, ovf_cnt}, 32'd0);
      #2;
      hrst_b = 1'b1;
      applyStimulus(IDLE, 32'h0, 1'b0, 32'hEEEE, 32'h0, 1'b1);
      checkOutput("post_rst_nopend", {27'd0, level}, 32'd0);
      applyStimulus(NONSEQ, 32'h400, 1'b1, 32'h0, 32'h0, 1'b1);
      applyStimulus(IDLE, 32'h0, 1'b0, 32'h77, 32'h0, 1'b1);
      applyStimulus(IDLE, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
      checkOutput("post_rst_level", {27'd0, level}, 32'd1);
      checkOutput("post_rst_addr", trc_addr, 32'h400);
      checkOutput("post_rst_data", trc_data, 32'h77);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
